pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage ARM-style pipeline. Drives freeze/flush/hold controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Sources of stalls and flushes: load-use and RAW hazards, taken branches, and a variable-latency SRAM handshake with timeout. Keeps saturating stall and flush statistics counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_if.sv | 56 +++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer: the FSM state
// encoding, the register-index width, the default SRAM timeout and the
// register-match helper used by the hazard detector.
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam int REG_W       = 4;
   localparam int TIMEOUT_DEF = 64;

   // True when a producing stage's destination feeds one of the ID operands.
   // The second operand only counts when the instruction really reads it.
   function automatic logic src_hit(input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] src1,
                                    input logic [REG_W-1:0] src2,
                                    input logic             two_src);
      return (dest == src1) | (two_src & (dest == src2));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   datapath -> ctrl : id_src1/id_src2/id_two_src, exe_wb_en/exe_mem_r_en/
//                      exe_dest, mem_wb_en/mem_dest/mem_r_en/mem_w_en,
//                      branch_taken, sram_ready
//   ctrl -> datapath : freeze_if, flush_if_id, flush_id_ex, hold_back,
//                      mem_req, mem_err, stall_cnt, flush_cnt
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_two_src;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [REG_W-1:0] exe_dest;
   logic             mem_wb_en;
   logic [REG_W-1:0] mem_dest;
   logic             mem_r_en;
   logic             mem_w_en;
   logic             branch_taken;
   logic             sram_ready;

   logic             freeze_if;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             hold_back;
   logic             mem_req;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_src1, id_src2, id_two_src,
      output exe_wb_en, exe_mem_r_en, exe_dest,
      output mem_wb_en, mem_dest, mem_r_en, mem_w_en,
      output branch_taken, sram_ready,
      input  freeze_if, flush_if_id, flush_id_ex, hold_back,
      input  mem_req, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_src1, id_src2, id_two_src,
      input  exe_wb_en, exe_mem_r_en, exe_dest,
      input  mem_wb_en, mem_dest, mem_r_en, mem_w_en,
      input  branch_taken, sram_ready,
      output freeze_if, flush_if_id, flush_id_ex, hold_back,
      output mem_req, mem_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears the count)
//   inc_i   : count one event this cycle
//   count_o : current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: step on an event unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. A MEM-stage load or
// store holds the whole pipeline until the SRAM answers (or the wait times
// out, which raises a sticky error). Outside a memory hold, a taken branch
// flushes IF/ID and ID/EX, otherwise a data hazard freezes IF and bubbles
// ID/EX. Stall and branch-flush cycles are counted with saturation.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : hazard inputs from the datapath, stage controls back,
//                  mem_err and the statistics counters
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FORWARD_EN = 1,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int CNT_W      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
   localparam bit                FWD      = (FORWARD_EN != 0);

   state_e            state_q;
   state_e            state_d;
   logic [WCNT_W-1:0] wcnt_q;
   logic [WCNT_W-1:0] wcnt_d;
   logic              err_q;
   logic              err_d;

   logic              mem_op_s;
   logic              exe_hit_s;
   logic              mem_hit_s;
   logic              hazard_s;
   logic              freeze_raw_s;
   logic              flush_ifid_raw_s;
   logic              flush_idex_raw_s;
   logic              hold_raw_s;
   logic              req_raw_s;
   logic              freeze_s;
   logic              branch_flush_s;
   logic [CNT_W-1:0]  stall_cnt_s;
   logic [CNT_W-1:0]  flush_cnt_s;

   assign mem_op_s  = bus.mem_r_en | bus.mem_w_en;
   assign exe_hit_s = src_hit(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_two_src);
   assign mem_hit_s = src_hit(bus.mem_dest, bus.id_src1, bus.id_src2, bus.id_two_src);

   // With forwarding only a load in EXE cannot be bypassed in time; without
   // it, any pending write in EXE or MEM must retire first.
   assign hazard_s = FWD ? (bus.exe_wb_en & bus.exe_mem_r_en & exe_hit_s)
                         : ((bus.exe_wb_en & exe_hit_s) | (bus.mem_wb_en & mem_hit_s));

   // Next state, wait counter, error flag and raw stage controls.
   always_comb begin
      state_d          = state_q;
      wcnt_d           = wcnt_q;
      err_d            = err_q;
      req_raw_s        = 1'b0;
      hold_raw_s       = 1'b0;
      freeze_raw_s     = 1'b0;
      flush_ifid_raw_s = 1'b0;
      flush_idex_raw_s = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_op_s) begin
               req_raw_s    = 1'b1;
               hold_raw_s   = 1'b1;
               freeze_raw_s = 1'b1;
               state_d      = ST_WAIT;
               wcnt_d       = WCNT_ONE;
            end else begin
               state_d      = ST_RUN;
            end
         end
         ST_WAIT: begin
            req_raw_s = 1'b1;
            if (bus.sram_ready) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_MAX) begin
               // Give up on the SRAM: release as if it answered, flag it.
               err_d   = 1'b1;
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else begin
               hold_raw_s   = 1'b1;
               freeze_raw_s = 1'b1;
               wcnt_d       = wcnt_q + WCNT_ONE;
            end
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = '0;
         end
      endcase

      // Branch and hazard only act when the memory is not holding the
      // pipeline; a branch held in EXE therefore fires in the release cycle.
      if (!hold_raw_s && bus.branch_taken) begin
         flush_ifid_raw_s = 1'b1;
         flush_idex_raw_s = 1'b1;
         freeze_raw_s     = 1'b0;
      end else if (!hold_raw_s && hazard_s) begin
         freeze_raw_s     = 1'b1;
         flush_idex_raw_s = 1'b1;
      end else begin
         flush_ifid_raw_s = 1'b0;
      end
   end

   // FSM state, wait counter and sticky error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   // Controls are forced quiet while reset is applied.
   assign freeze_s       = freeze_raw_s & ~rst_i;
   assign branch_flush_s = flush_ifid_raw_s & ~rst_i;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (freeze_s),
      .count_o (stall_cnt_s)
   );

   // Only a branch raises flush_if_id, so it marks a branch-flush cycle.
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (branch_flush_s),
      .count_o (flush_cnt_s)
   );

   assign bus.freeze_if   = freeze_s;
   assign bus.flush_if_id = branch_flush_s;
   assign bus.flush_id_ex = flush_idex_raw_s & ~rst_i;
   assign bus.hold_back   = hold_raw_s & ~rst_i;
   assign bus.mem_req     = req_raw_s & ~rst_i;
   assign bus.mem_err     = err_q;
   assign bus.stall_cnt   = stall_cnt_s;
   assign bus.flush_cnt   = flush_cnt_s;

endmodule
